// File: rtl/cpu_pkg.sv
// Shared MIPS32 front-end types: word-address and instruction widths, reset PC,
// and the {pc, instr} entry carried through the fetch queue.
package cpu_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 6'd0;

  typedef logic [DATA_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0] waddr_t;

  typedef struct packed {
    waddr_t pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry circular buffer of fetch entries: two in-order write ports,
// one read port (head), synchronous flush. push2_i is only honoured with push1_i.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push1_i,
  input  logic             push2_i,
  input  fetch_entry_t     wr1_i,
  input  fetch_entry_t     wr2_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       n_push_s;

  // Pointer/occupancy next state; flush overrides any push or pop.
  always_comb begin
    n_push_s = 2'd0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push1_i && push2_i) begin
        n_push_s = 2'd2;
      end else if (push1_i) begin
        n_push_s = 2'd1;
      end else begin
        n_push_s = 2'd0;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(n_push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      count_d  = count_q + CNT_W'(n_push_s) - CNT_W'(pop_i);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; second word lands in the slot after the first (wrapping).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!flush_i) begin
      if (push1_i) begin
        mem_q[wr_ptr_q] <= wr1_i;
      end
      if (push1_i && push2_i) begin
        mem_q[wr_ptr_q + PTR_W'(1)] <= wr2_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: two ROM words per cycle into an in-order queue,
// valid/ready hand-out, flush on redirect. IFQ_STATS_EN adds fetch/full counters.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int     DEPTH    = 4,
  parameter waddr_t RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              CLK,
  input  logic              RST_N,
  output waddr_t            ROM_A1,
  output waddr_t            ROM_A2,
  input  instr_t            ROM_RD1,
  input  instr_t            ROM_RD2,
  input  logic              redirect_valid,
  input  waddr_t            redirect_pc,
`ifdef IFQ_STATS_EN
  output logic [15:0]       stat_fetched,
  output logic [15:0]       stat_full,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output waddr_t            out_pc,
  output instr_t            out_instr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  waddr_t           fpc_q, fpc_d;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] free_s;
  logic             push1_s, push2_s, pop_s;
  fetch_entry_t     wr1_s, wr2_s, head_s;

  assign ROM_A1 = fpc_q;
  assign ROM_A2 = fpc_q + ADDR_W'(1);

  // Credit comes from the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    free_s  = CNT_W'(DEPTH) - count_s;
    push1_s = 1'b0;
    push2_s = 1'b0;
    fpc_d   = fpc_q;
    pop_s   = out_valid & out_ready & ~redirect_valid;
    if (redirect_valid) begin
      fpc_d = redirect_pc;
    end else if (free_s >= CNT_W'(2)) begin
      push1_s = 1'b1;
      push2_s = 1'b1;
      fpc_d   = fpc_q + ADDR_W'(2);
    end else if (free_s == CNT_W'(1)) begin
      push1_s = 1'b1;
      fpc_d   = fpc_q + ADDR_W'(1);
    end else begin
      fpc_d = fpc_q;
    end
  end

  // Fetch PC register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fpc_q <= RESET_PC;
    end else begin
      fpc_q <= fpc_d;
    end
  end

  assign wr1_s = '{pc: ROM_A1, instr: ROM_RD1};
  assign wr2_s = '{pc: ROM_A2, instr: ROM_RD2};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .flush_i (redirect_valid),
    .push1_i (push1_s),
    .push2_i (push2_s),
    .wr1_i   (wr1_s),
    .wr2_i   (wr2_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

  assign out_valid = (count_s != {CNT_W{1'b0}});
  assign out_pc    = head_s.pc;
  assign out_instr = head_s.instr;

`ifdef IFQ_STATS_EN
  logic [15:0] stat_fetched_q, stat_full_q;

  // Free-running counters; redirect deliberately leaves them alone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_fetched_q <= 16'd0;
      stat_full_q    <= 16'd0;
    end else begin
      stat_fetched_q <= stat_fetched_q + 16'(push1_s) + 16'(push2_s);
      stat_full_q    <= stat_full_q + 16'(count_s == CNT_W'(DEPTH));
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_full    = stat_full_q;
`endif

endmodule
